rf_write_arbiter: RTL

Shares the single register-file write port (we3/wa3/wd3) between NUM_REQ writeback requesters, such as the ALU writeback, the load unit and the multi-cycle mul/div unit. Arbitration is round-robin with a valid/ready handshake. The winning request is registered and driven onto the write port one cycle later, so the register file's same-cycle read bypass covers the in-flight write. The block also counts contention cycles for performance debug.

---
 rtl/rf_arb_pkg.sv | 17 +
 rtl/rr_pick.sv | 42 ++++
 rtl/rf_write_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
//   REG_ADDR_W / REG_DATA_W : default register-file address / data widths
//   RF_ZERO_REG             : hard-wired zero register; writes to it are dropped
//   rf_wr_t                 : write-port triple {we, addr, data}
package rf_arb_pkg;

  localparam int unsigned REG_ADDR_W  = 5;
  localparam int unsigned REG_DATA_W  = 32;
  localparam int unsigned RF_ZERO_REG = 0;

  typedef struct packed {
    logic                  we;
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
//   req_i : request vector
//   ptr_i : highest-priority index; the scan ascends from here and wraps at N
//   gnt_o : one-hot grant (zero when no request)
//   idx_o : encoded index of the granted request
//   any_o : a grant was issued
module rr_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [N-1:0]         gnt_o,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned SUM_W = IDX_W + 1;

  // First requester at or after ptr_i, wrapping modulo N
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic             found;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    sum   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + SUM_W'(k);
      if (sum >= SUM_W'(N)) begin
        sum = sum - SUM_W'(N);
      end
      if (!found && req_i[sum[IDX_W-1:0]]) begin
        gnt_o[sum[IDX_W-1:0]] = 1'b1;
        idx_o                 = sum[IDX_W-1:0];
        found                 = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_REQ
// writeback requesters. The winner is registered and driven one cycle later.
//   clk, reset_n          : clock, asynchronous active-low reset
//   req_valid/addr/data   : per-requester request, address and data (sliced)
//   req_ready             : one-hot grant (combinational, gated by hold)
//   hold                  : pipeline freeze, blocks new grants
//   we3/wa3/wd3           : registered register-file write port
//   conflict_cnt          : saturating count of contention cycles
module rf_write_arbiter
  import rf_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned DATA_W  = REG_DATA_W,
  parameter int unsigned ADDR_W  = REG_ADDR_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        hold,
  output logic                        we3,
  output logic [ADDR_W-1:0]           wa3,
  output logic [DATA_W-1:0]           wd3,
  output logic [CNT_W-1:0]            conflict_cnt
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned POP_W = $clog2(NUM_REQ + 1);

  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               we3_q, we3_d;
  logic [ADDR_W-1:0]  wa3_q, wa3_d;
  logic [DATA_W-1:0]  wd3_q, wd3_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NUM_REQ-1:0] elig_c;
  logic [NUM_REQ-1:0] gnt_c;
  logic [PTR_W-1:0]   gnt_idx_c;
  logic               gnt_any_c;
  logic [ADDR_W-1:0]  win_addr_c;
  logic [DATA_W-1:0]  win_data_c;
  logic [POP_W-1:0]   pop_c;
  logic               contend_c;

  // hold suppresses all grants without disturbing the pointer
  assign elig_c = hold ? '0 : req_valid;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req_i (elig_c),
    .ptr_i (rr_ptr_q),
    .gnt_o (gnt_c),
    .idx_o (gnt_idx_c),
    .any_o (gnt_any_c)
  );

  assign req_ready = gnt_c;

  // AND-OR mux of the winning slice (grant is one-hot or zero)
  always_comb begin
    win_addr_c = '0;
    win_data_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_c[i]) begin
        win_addr_c = win_addr_c | req_addr[i*ADDR_W +: ADDR_W];
        win_data_c = win_data_c | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Contention: two or more valid requesters while not frozen
  always_comb begin
    pop_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pop_c = pop_c + POP_W'(req_valid[i]);
    end
  end

  assign contend_c = !hold && (pop_c >= POP_W'(2));

  // Next-state: write register, pointer and counter
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    we3_d    = 1'b0;
    wa3_d    = wa3_q;
    wd3_d    = wd3_q;
    cnt_d    = cnt_q;
    if (gnt_any_c) begin
      // Zero-register writes are consumed but never enabled
      we3_d    = (win_addr_c != ADDR_W'(RF_ZERO_REG));
      wa3_d    = win_addr_c;
      wd3_d    = win_data_c;
      rr_ptr_d = (gnt_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + PTR_W'(1);
    end
    if (contend_c && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q <= '0;
      we3_q    <= 1'b0;
      wa3_q    <= '0;
      wd3_q    <= '0;
      cnt_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      we3_q    <= we3_d;
      wa3_q    <= wa3_d;
      wd3_q    <= wd3_d;
      cnt_q    <= cnt_d;
    end
  end

  assign we3          = we3_q;
  assign wa3          = wa3_q;
  assign wd3          = wd3_q;
  assign conflict_cnt = cnt_q;

endmodule
